int_ctrl: RTL and testbench
===========================

Name: int_ctrl

Overview:
- Parametrised, memory-mapped interrupt controller for the 8-bit CPU.
- Replaces the single UART interrupt line and single vector register with NUM_SRC prioritised sources.
- Each source has per-source enable, edge/level mode and an 8-bit vector. Adds a global enable and a request/ack/end-of-interrupt handshake.
- Sits on the CPU data bus (rs_data/rd_data/mem_w_en) beside data_mem; drives the CPU int_req and int_vec inputs.

Parameters:
- NUM_SRC, 4, number of interrupt sources (1..8); index 0 has the highest priority.
- BASE_ADDR, 8'd224, first address of the register window; window size is 6+NUM_SRC.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- addr  in  8  data-bus address (CPU rs_data).
- w_data  in  8  write data (CPU rd_data).
- w_en  in  1  write strobe (CPU mem_w_en).
- r_data  out  8  read data; combinational from addr.
- r_hit  out  1  1 when addr is inside the window; top level muxes r_data onto mem_r_data.
- src_req  in  NUM_SRC  interrupt source lines, synchronous to clock.
- int_req  out  1  interrupt request to the CPU.
- int_vec  out  8  vector of the requesting source; valid while int_req=1.
- int_ack  in  1  one-cycle pulse from the CPU when it takes the interrupt.

Behaviour:
- Register map (offset from BASE_ADDR). Bits at or above NUM_SRC read 0 and ignore writes. Unused offsets read 0.
  - 0 ENABLE: RW.
  - 1 PENDING: RO, except write-1-to-clear for edge-mode bits.
  - 2 MODE: RW; 1 = edge, 0 = level.
  - 3 ACTIVE: RO; {valid, 4'b0, id[2:0]}.
  - 4 EOI: write any value to end service; reads 0.
  - 5 GLOBAL: bit0 is the global enable, RW.
  - 6+i VEC[i]: RW.
- Reset (asynchronous, immediate, also mid-handshake):
  - All registers 0; prev_src = 0; state IDLE.
  - int_req = 0, int_vec = 0, ACTIVE = 0.
- Pending logic:
  - Edge-mode bit sets on a cycle where src_req[i]=1 and prev_src[i]=0; it stays set until W1C or ack.
  - Level-mode bit equals src_req[i] registered: 1 cycle latency, no latching.
  - An edge-set coinciding with a W1C clear or an ack clear on the same bit: the set wins.
- Arbitration: sel = lowest index with PENDING & ENABLE set; considered only when GLOBAL[0]=1.
- States:
  - IDLE: if a candidate exists, latch id = sel and go to REQ.
  - REQ: int_req = 1, int_vec = VEC[id]; id is frozen and a higher-priority arrival does not preempt.
    - On int_ack: go to SERVICE. If the source is edge mode, clear PENDING[id] in the same cycle.
    - If ENABLE[id] or GLOBAL[0] is cleared, or level PENDING[id] drops, before ack: withdraw to IDLE and drop int_req next cycle.
    - An ack arriving in the same cycle as a withdraw condition: the ack wins.
  - SERVICE: int_req = 0; ACTIVE = {1, id}; no new request, which gives nested-interrupt blocking.
    - A write to EOI returns to IDLE. An EOI write while in IDLE or REQ is ignored.
    - A level source still asserted after EOI re-requests: 1 cycle to IDLE, then REQ.
- Latency:
  - Edge on src_req at cycle t: PENDING at t+1, int_req at t+2.
  - int_ack at t: int_req = 0 at t+1.
- Writes take effect at the clock edge. A write to VEC[id] during REQ updates int_vec next cycle.
- int_ack outside REQ is ignored.

Decomposition:
- Package int_ctrl_pkg holds:
  - register offset constants OFS_ENABLE..OFS_VEC0;
  - the state encoding IDLE/REQ/SERVICE;
  - ID_W = 3.
- Sub-module int_prio_enc: combinational fixed-priority encoder, NUM_SRC-wide in, outputs {valid, id}.
- Pending, register file and FSM stay in int_ctrl.

Test Plan:
- Reset mid-REQ: NUM_SRC=4, GLOBAL=1, ENABLE=4'b0001, MODE=1, VEC[0]=8'h40; pulse src_req[0] -> int_req rises 2 cycles later with int_vec=8'h40; assert reset -> int_req=0 and PENDING=0 immediately.
- Priority: VEC[1]=8'h50, VEC[2]=8'h60, edge mode; pulse src_req[2] and src_req[1] in the same cycle -> int_vec=8'h50; ack then EOI -> next request int_vec=8'h60.
- No preemption: src 2 in REQ, then pulse src 0 before ack -> int_vec stays 8'h60 until ack; after EOI -> src 0 requested.
- Level re-request: MODE=0, hold src_req[3]=1, ack then EOI -> int_req reasserts 2 cycles after EOI; drop src_req[3] while in REQ -> withdraw to IDLE, int_req=0.
- W1C vs edge collision: pending bit 1 set; write 8'h02 to PENDING in the same cycle as a new edge on src 1 -> PENDING[1] stays 1.
- Masking and bus: GLOBAL=0 with pending set -> int_req stays 0; ACTIVE reads 8'h82 in SERVICE for id 2; addr outside the window -> r_hit=0.

Source files
------------

// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller.
// Register offsets are relative to the controller's BASE_ADDR. ID_W is the
// width of a source index, enough for up to 8 sources.
package int_ctrl_pkg;

  localparam int unsigned ID_W = 3;

  localparam logic [7:0] OFS_ENABLE  = 8'd0;
  localparam logic [7:0] OFS_PENDING = 8'd1;
  localparam logic [7:0] OFS_MODE    = 8'd2;
  localparam logic [7:0] OFS_ACTIVE  = 8'd3;
  localparam logic [7:0] OFS_EOI     = 8'd4;
  localparam logic [7:0] OFS_GLOBAL  = 8'd5;
  localparam logic [7:0] OFS_VEC0    = 8'd6;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StService
  } state_e;

endpackage

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder. Index 0 has the highest priority.
// Ports:
//   req_i   - request vector, NUM_SRC wide
//   valid_o - 1 when any request bit is set
//   id_o    - index of the lowest set bit (0 when none)
module int_prio_enc
  import int_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] req_i,
  output logic               valid_o,
  output logic [ID_W-1:0]    id_o
);

  always_comb begin
    valid_o = |req_i;
    id_o    = '0;
    // Scan from the top down so the lowest set index is written last.
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req_i[i]) id_o = ID_W'(i);
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Memory-mapped interrupt controller for the 8-bit CPU.
// NUM_SRC prioritised sources, each with enable, edge/level mode and an 8-bit
// vector, plus a global enable and a request/ack/EOI handshake.
// Ports:
//   clock, reset      - system clock, asynchronous active-high reset
//   addr, w_data, w_en - CPU data-bus address, write data and write strobe
//   r_data, r_hit     - combinational read data and window-hit flag
//   src_req           - interrupt source lines, synchronous to clock
//   int_req, int_vec  - request and vector to the CPU
//   int_ack           - one-cycle pulse when the CPU takes the interrupt
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SRC   = 4,
  parameter logic [7:0]  BASE_ADDR = 8'd224
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [7:0]         addr,
  input  logic [7:0]         w_data,
  input  logic               w_en,
  output logic [7:0]         r_data,
  output logic               r_hit,
  input  logic [NUM_SRC-1:0] src_req,
  output logic               int_req,
  output logic [7:0]         int_vec,
  input  logic               int_ack
);

  localparam logic [7:0] WinSize = 8'(6 + NUM_SRC);
  localparam logic [7:0] SrcMask = 8'((1 << NUM_SRC) - 1);

  // Per-source state is kept 8 wide so a 3-bit id indexes it directly;
  // bits at or above NUM_SRC are never set and stay 0.
  logic [7:0] enable_q, enable_d;
  logic [7:0] pending_q, pending_d;
  logic [7:0] mode_q, mode_d;
  logic [7:0] prev_src_q;
  logic       glb_q, glb_d;
  logic [7:0] vec_q [8];
  logic [7:0] vec_d [8];

  state_e          state_q, state_d;
  logic [ID_W-1:0] id_q, id_d;

  logic [7:0]         off;
  logic               wr, wr_eoi, ack_take;
  logic [7:0]         src_ext;
  logic [NUM_SRC-1:0] cand;
  logic               cand_valid;
  logic [ID_W-1:0]    sel;
  logic [7:0]         active;

  assign off      = addr - BASE_ADDR;
  assign r_hit    = (addr >= BASE_ADDR) && (off < WinSize);
  assign wr       = w_en & r_hit;
  assign wr_eoi   = wr && (off == OFS_EOI);
  assign ack_take = (state_q == StReq) && int_ack;
  assign src_ext  = 8'(src_req);
  assign cand     = NUM_SRC'(pending_q & enable_q);

  int_prio_enc #(
    .NUM_SRC(NUM_SRC)
  ) u_prio_enc (
    .req_i  (cand),
    .valid_o(cand_valid),
    .id_o   (sel)
  );

  // Register file and pending next-state.
  always_comb begin
    enable_d  = enable_q;
    mode_d    = mode_q;
    glb_d     = glb_q;
    vec_d     = vec_q;
    pending_d = '0;
    if (wr) begin
      case (off)
        OFS_ENABLE: enable_d = w_data & SrcMask;
        OFS_MODE:   mode_d   = w_data & SrcMask;
        OFS_GLOBAL: glb_d    = w_data[0];
        default: ;
      endcase
    end
    for (int k = 0; k < NUM_SRC; k++) begin
      if (wr && (off == OFS_VEC0 + 8'(k))) vec_d[k] = w_data;
    end
    for (int k = 0; k < 8; k++) begin
      if (mode_q[k]) begin
        pending_d[k] = pending_q[k];
        if (wr && (off == OFS_PENDING) && w_data[k]) pending_d[k] = 1'b0;
        if (ack_take && (id_q == ID_W'(k)))          pending_d[k] = 1'b0;
        // A fresh edge beats any clear in the same cycle.
        if (src_ext[k] && !prev_src_q[k])            pending_d[k] = 1'b1;
      end else begin
        pending_d[k] = src_ext[k];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      enable_q   <= '0;
      pending_q  <= '0;
      mode_q     <= '0;
      prev_src_q <= '0;
      glb_q      <= 1'b0;
      for (int k = 0; k < 8; k++) vec_q[k] <= '0;
    end else begin
      enable_q   <= enable_d;
      pending_q  <= pending_d;
      mode_q     <= mode_d;
      prev_src_q <= src_ext;
      glb_q      <= glb_d;
      vec_q      <= vec_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
    end
  end

  // FSM next state. The id is frozen once in StReq: no preemption.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    unique case (state_q)
      StIdle: begin
        if (glb_q && cand_valid) begin
          state_d = StReq;
          id_d    = sel;
        end
      end
      StReq: begin
        // Ack takes precedence over any withdraw condition.
        if (int_ack) begin
          state_d = StService;
        end else if (!enable_q[id_q] || !glb_q ||
                     (!mode_q[id_q] && !pending_q[id_q])) begin
          state_d = StIdle;
        end
      end
      StService: begin
        if (wr_eoi) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    int_req = 1'b0;
    int_vec = '0;
    active  = '0;
    unique case (state_q)
      StReq: begin
        int_req = 1'b1;
        int_vec = vec_q[id_q];
      end
      StService: active = {1'b1, 4'b0000, id_q};
      default: ;
    endcase
  end

  // Combinational read mux.
  always_comb begin
    r_data = '0;
    if (r_hit) begin
      case (off)
        OFS_ENABLE:  r_data = enable_q;
        OFS_PENDING: r_data = pending_q;
        OFS_MODE:    r_data = mode_q;
        OFS_ACTIVE:  r_data = active;
        OFS_EOI:     r_data = '0;
        OFS_GLOBAL:  r_data = {7'b0000000, glb_q};
        default: begin
          if (off >= OFS_VEC0) r_data = vec_q[3'(off - OFS_VEC0)];
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl (NUM_SRC = 4, BASE_ADDR = 224).
// Expected vectors are queued when a source is stimulated and popped by a
// monitor on every rising edge of int_req.
module tb_int_ctrl;

  localparam logic [7:0] Base = 8'd224;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] addr, w_data, r_data, int_vec;
  logic       w_en, r_hit, int_req, int_ack;
  logic [3:0] src_req;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  logic       req_prev = 1'b0;

  int_ctrl #(
    .NUM_SRC  (4),
    .BASE_ADDR(Base)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .addr   (addr),
    .w_data (w_data),
    .w_en   (w_en),
    .r_data (r_data),
    .r_hit  (r_hit),
    .src_req(src_req),
    .int_req(int_req),
    .int_vec(int_vec),
    .int_ack(int_ack)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic bus_wr(input logic [7:0] ofs, input logic [7:0] d);
    addr   = Base + ofs;
    w_data = d;
    w_en   = 1'b1;
    tick();
    w_en   = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] ofs, input logic [7:0] exp);
    addr = Base + ofs;
    #1;
    check_eq(tag, r_data, exp);
  endtask

  task automatic pulse(input logic [3:0] mask);
    src_req = mask;
    tick();
    src_req = 4'b0000;
  endtask

  task automatic do_ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 20 && !int_req; i++) tick();
    check_eq(tag, 8'(int_req), 8'd1);
  endtask

  // Scoreboard: each new request must match the oldest queued vector.
  always @(negedge clock) begin
    if (int_req && !req_prev) begin
      check_eq("sb_expected", 8'(exp_q.size() != 0), 8'd1);
      if (exp_q.size() != 0) check_eq("sb_int_vec", int_vec, exp_q.pop_front());
    end
    req_prev <= int_req;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    addr = Base; w_data = 8'h00; w_en = 1'b0; src_req = 4'b0000; int_ack = 1'b0;
    tick(2);
    reset = 1'b0;
    tick();

    // Reset state.
    check_eq("rst_int_req", 8'(int_req), 8'd0);
    check_eq("rst_int_vec", int_vec, 8'h00);
    rd_chk("rst_enable", 8'd0, 8'h00);
    rd_chk("rst_pending", 8'd1, 8'h00);
    rd_chk("rst_active", 8'd3, 8'h00);
    rd_chk("rst_global", 8'd5, 8'h00);
    tick();

    // Window decode.
    addr = 8'd223; #1; check_eq("hit_below", 8'(r_hit), 8'd0);
    addr = 8'd224; #1; check_eq("hit_first", 8'(r_hit), 8'd1);
    addr = 8'd233; #1; check_eq("hit_last", 8'(r_hit), 8'd1);
    addr = 8'd234; #1; check_eq("hit_above", 8'(r_hit), 8'd0);
    tick();

    // Reset in the middle of a request.
    bus_wr(8'd5, 8'h01);
    bus_wr(8'd0, 8'h01);
    bus_wr(8'd2, 8'h01);
    bus_wr(8'd6, 8'h40);
    exp_q.push_back(8'h40);
    pulse(4'b0001);
    check_eq("lat_t1_req", 8'(int_req), 8'd0);
    rd_chk("lat_t1_pending", 8'd1, 8'h01);
    tick();
    check_eq("lat_t2_req", 8'(int_req), 8'd1);
    check_eq("lat_t2_vec", int_vec, 8'h40);
    @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
    check_eq("midreq_rst_req", 8'(int_req), 8'd0);
    check_eq("midreq_rst_vec", int_vec, 8'h00);
    rd_chk("midreq_rst_pending", 8'd1, 8'h00);
    tick();
    reset = 1'b0;
    tick();

    // Configuration; enable bits above NUM_SRC are dropped.
    bus_wr(8'd5, 8'h01);
    bus_wr(8'd0, 8'hFF);
    rd_chk("enable_mask", 8'd0, 8'h0F);
    bus_wr(8'd2, 8'h07);
    bus_wr(8'd6, 8'h40);
    bus_wr(8'd7, 8'h50);
    bus_wr(8'd8, 8'h60);
    bus_wr(8'd9, 8'h70);
    rd_chk("vec3_rb", 8'd9, 8'h70);

    // Priority between simultaneous edges.
    exp_q.push_back(8'h50);
    exp_q.push_back(8'h60);
    pulse(4'b0110);
    tick();
    check_eq("prio_vec", int_vec, 8'h50);
    do_ack();
    check_eq("ack_drop", 8'(int_req), 8'd0);
    rd_chk("active_id1", 8'd3, 8'h81);
    rd_chk("ack_clear_pend", 8'd1, 8'h04);
    rd_chk("eoi_reads0", 8'd4, 8'h00);
    bus_wr(8'd4, 8'h00);
    tick();
    check_eq("next_req", 8'(int_req), 8'd1);
    check_eq("next_vec", int_vec, 8'h60);

    // No preemption by a higher-priority arrival.
    exp_q.push_back(8'h40);
    pulse(4'b0001);
    tick();
    check_eq("nopreempt_vec", int_vec, 8'h60);
    check_eq("nopreempt_req", 8'(int_req), 8'd1);
    do_ack();
    rd_chk("active_id2", 8'd3, 8'h82);
    check_eq("service_noreq", 8'(int_req), 8'd0);
    bus_wr(8'd4, 8'h00);
    tick();
    check_eq("after_eoi_vec", int_vec, 8'h40);
    do_ack();
    bus_wr(8'd4, 8'h00);
    tick(2);
    check_eq("idle_noreq", 8'(int_req), 8'd0);
    rd_chk("idle_pending", 8'd1, 8'h00);

    // Level source: re-request after EOI, withdraw when dropped.
    exp_q.push_back(8'h70);
    src_req = 4'b1000;
    tick(2);
    check_eq("lvl_req", 8'(int_req), 8'd1);
    do_ack();
    exp_q.push_back(8'h70);
    rd_chk("lvl_pend_held", 8'd1, 8'h08);
    bus_wr(8'd4, 8'h00);
    check_eq("lvl_eoi_idle", 8'(int_req), 8'd0);
    tick();
    check_eq("lvl_rereq", 8'(int_req), 8'd1);
    src_req = 4'b0000;
    tick();
    check_eq("lvl_hold", 8'(int_req), 8'd1);
    tick();
    check_eq("lvl_withdraw", 8'(int_req), 8'd0);
    tick();
    rd_chk("lvl_pend_drop", 8'd1, 8'h00);

    // Global mask, W1C and W1C/edge collision.
    bus_wr(8'd5, 8'h00);
    pulse(4'b0010);
    tick(2);
    check_eq("global_masked", 8'(int_req), 8'd0);
    rd_chk("masked_pend", 8'd1, 8'h02);
    bus_wr(8'd1, 8'h02);
    rd_chk("w1c_clear", 8'd1, 8'h00);
    pulse(4'b0010);
    tick();
    addr = Base + 8'd1; w_data = 8'h02; w_en = 1'b1; src_req = 4'b0010;
    tick();
    w_en = 1'b0; src_req = 4'b0000;
    rd_chk("w1c_collide", 8'd1, 8'h02);
    exp_q.push_back(8'h50);
    bus_wr(8'd5, 8'h01);
    wait_req("unmask_req");
    do_ack();
    bus_wr(8'd4, 8'h00);

    tick(3);
    check_eq("sb_drain", 8'(exp_q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
